// File: rtl/lsb_pkg.sv
// Shared framing constants and state encoding for the LSB stego embedder/extractor pair.
`timescale 1ns/1ps
package lsb_pkg;

    localparam int DEF_IMG_WIDTH       = 100;
    localparam int DEF_IMG_HEIGHT      = 100;
    localparam int DEF_BYTES_PER_PIXEL = 3;
    localparam int DEF_TOTAL_BYTES     = DEF_IMG_WIDTH * DEF_IMG_HEIGHT * DEF_BYTES_PER_PIXEL;
    localparam int DEF_FIFO_DEPTH      = 16;

    // End-of-message marker ('.'); it is itself part of the recovered message.
    localparam logic [7:0] TERMINATOR = 8'h2E;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXTRACT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } lsb_state_e;

    // Message length counter holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous clear.
// Read data reads as zero while empty so the output never shows stale entries.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; clear has priority over any same-cycle push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lsb_extractor.sv
// Recovers a hidden message from the LSBs of a stego image byte stream and
// streams the characters out through a FIFO on a valid/ready interface.
//
// state   | meaning
// IDLE    | after reset, waiting for start; no image bytes taken
// EXTRACT | collecting LSBs, pushing a char every 8 accepted bytes
// DRAIN   | message ended (terminator or frame end); emptying the FIFO
// DONE    | FIFO empty; sinking and discarding the rest of the frame
`timescale 1ns/1ps
module lsb_extractor
    import lsb_pkg::*;
#(
    parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT,
    parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        image_valid,
    input  logic [7:0]  image_byte_in,
    output logic        image_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic [15:0] msg_len,
    output logic        done,
    output logic        no_term
);
    localparam int TOTAL_BYTES = IMG_WIDTH * IMG_HEIGHT * BYTES_PER_PIXEL;
    localparam int BCW         = $clog2(TOTAL_BYTES + 1);
    localparam int FCW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] FRAME_LEN  = BCW'(TOTAL_BYTES);
    localparam logic [BCW-1:0] FRAME_LAST = BCW'(TOTAL_BYTES - 1);

    lsb_state_e     state;
    lsb_state_e     state_nx;
    logic [2:0]     bit_cnt;
    logic [6:0]     shift;
    logic [BCW-1:0] byte_cnt;
    logic           accept;
    logic           push;
    logic           pop;
    logic [7:0]     push_data;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic           set_no_term;
    logic           set_done;
    logic           unused_bits;

    // Only bit 0 of each image byte carries message data.
    assign unused_bits = ^image_byte_in[7:1];

    assign accept    = image_valid && image_ready;
    assign push_data = {image_byte_in[0], shift};
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state, input handshake and char push; start re-arms from any state.
    always_comb begin
        state_nx    = state;
        image_ready = 1'b0;
        push        = 1'b0;
        set_no_term = 1'b0;
        set_done    = 1'b0;
        case (state)
            EXTRACT: begin
                // A full FIFO only blocks the byte that would complete a char.
                image_ready = !((bit_cnt == 3'd7) && fifo_full);
                if (image_valid && image_ready) begin
                    push = (bit_cnt == 3'd7);
                    if (push && (push_data == TERMINATOR)) begin
                        state_nx = DRAIN;
                    end else if (byte_cnt == FRAME_LAST) begin
                        state_nx    = DRAIN;
                        set_no_term = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Treat the final pop as emptying so done follows it by one cycle.
                if (fifo_empty || (pop && (fifo_count == FCW'(1)))) begin
                    state_nx = DONE;
                    set_done = 1'b1;
                end
            end
            DONE: begin
                image_ready = (byte_cnt < FRAME_LEN);
            end
            default: begin
            end
        endcase
        if (start) begin
            state_nx    = EXTRACT;
            push        = 1'b0;
            set_no_term = 1'b0;
            set_done    = 1'b0;
        end
    end

    // Bit/byte counters, char assembly and message length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            byte_cnt <= '0;
            msg_len  <= '0;
        end else if (start) begin
            bit_cnt  <= '0;
            shift    <= '0;
            byte_cnt <= '0;
            msg_len  <= '0;
        end else begin
            if (accept && (byte_cnt != FRAME_LEN)) byte_cnt <= byte_cnt + BCW'(1);
            if (accept && (state == EXTRACT)) begin
                if (bit_cnt != 3'd7) shift[bit_cnt] <= image_byte_in[0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (push) msg_len <= sat_inc16(msg_len);
        end
    end

    // Sticky completion flags, cleared only by start or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            no_term <= 1'b0;
        end else if (start) begin
            done    <= 1'b0;
            no_term <= 1'b0;
        end else begin
            if (set_done)    done    <= 1'b1;
            if (set_no_term) no_term <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .push  (push),
        .wdata (push_data),
        .pop   (pop),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
